apb2axi_32_64: RTL and testbench

Bridge from a 32-bit APB completer port to a 64-bit AXI4 single-beat initiator. It lets APB-side masters (debug/config agents on the peripheral side) reach AXI slaves such as memory or the crossbar, which is the reverse direction of the peripheral `axi2apb_64_32` bridges. Each APB access phase produces exactly one AXI read or write burst of length 1. The APB transfer is held with `pready` low until the AXI response returns.

---
 rtl/apb2axi_32_64_if.sv | 87 ++++++++
 rtl/apb2axi_32_64.sv | 218 +++++++++++++++++++++
 tb/tb_apb2axi_32_64.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/apb2axi_32_64_if.sv
// AXI4 bus bundle used by the APB-to-AXI bridge and its environment.
// Carries all five channels; the Master modport is the initiator view.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic                        aw_lock;
    logic [3:0]                  aw_cache;
    logic [2:0]                  aw_prot;
    logic [3:0]                  aw_qos;
    logic [3:0]                  aw_region;
    logic [AXI_USER_WIDTH-1:0]   aw_user;
    logic                        aw_valid;
    logic                        aw_ready;

    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic [AXI_USER_WIDTH-1:0]   w_user;
    logic                        w_valid;
    logic                        w_ready;

    logic [AXI_ID_WIDTH-1:0]     b_id;
    logic [1:0]                  b_resp;
    logic [AXI_USER_WIDTH-1:0]   b_user;
    logic                        b_valid;
    logic                        b_ready;

    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic                        ar_lock;
    logic [3:0]                  ar_cache;
    logic [2:0]                  ar_prot;
    logic [3:0]                  ar_qos;
    logic [3:0]                  ar_region;
    logic [AXI_USER_WIDTH-1:0]   ar_user;
    logic                        ar_valid;
    logic                        ar_ready;

    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic [AXI_USER_WIDTH-1:0]   r_user;
    logic                        r_valid;
    logic                        r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/apb2axi_32_64.sv
// APB (32-bit completer) to AXI4 (64-bit, single-beat initiator) bridge.
// One APB access phase becomes exactly one AXI burst of length 1; the APB
// side is held off with pready low until the AXI response has returned.
module apb2axi_32_64 #(
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned AxiUserWidth = 1,
    parameter int unsigned AxiId        = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [31:0] paddr_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    AXI_BUS.Master      axi
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        WAIT_B = 3'd2,
        RD     = 3'd3,
        WAIT_R = 3'd4,
        DONE   = 3'd5
    } state_e;

    state_e      state_r, state_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] wdata_r, wdata_s;
    logic [31:0] prdata_r, prdata_s;
    logic        aw_valid_r, aw_valid_s;
    logic        w_valid_r, w_valid_s;
    logic        ar_valid_r, ar_valid_s;
    logic        b_ready_r, b_ready_s;
    logic        r_ready_r, r_ready_s;
    logic        pready_r, pready_s;
    logic        pslverr_r, pslverr_s;
    logic        aw_done_s;
    logic        w_done_s;

    // A channel counts as done once its valid has dropped or is handshaking now.
    assign aw_done_s = ~aw_valid_r | axi.aw_ready;
    assign w_done_s  = ~w_valid_r  | axi.w_ready;

    // Next-state and next-output logic; all outputs are registered from these.
    always_comb begin
        state_s    = state_r;
        addr_s     = addr_r;
        wdata_s    = wdata_r;
        prdata_s   = prdata_r;
        aw_valid_s = aw_valid_r;
        w_valid_s  = w_valid_r;
        ar_valid_s = ar_valid_r;
        b_ready_s  = 1'b0;
        r_ready_s  = 1'b0;
        pready_s   = 1'b0;
        pslverr_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (psel_i && penable_i) begin
                    if (paddr_i[1:0] != 2'b00) begin
                        // Misaligned: answer with an error, no AXI traffic.
                        state_s   = DONE;
                        pready_s  = 1'b1;
                        pslverr_s = 1'b1;
                    end else begin
                        addr_s  = paddr_i;
                        wdata_s = pwdata_i;
                        if (pwrite_i) begin
                            state_s    = WR;
                            aw_valid_s = 1'b1;
                            w_valid_s  = 1'b1;
                        end else begin
                            state_s    = RD;
                            ar_valid_s = 1'b1;
                        end
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WR: begin
                if (aw_valid_r && axi.aw_ready) begin
                    aw_valid_s = 1'b0;
                end else begin
                    aw_valid_s = aw_valid_r;
                end
                if (w_valid_r && axi.w_ready) begin
                    w_valid_s = 1'b0;
                end else begin
                    w_valid_s = w_valid_r;
                end
                if (aw_done_s && w_done_s) begin
                    state_s   = WAIT_B;
                    b_ready_s = 1'b1;
                end else begin
                    state_s = WR;
                end
            end
            WAIT_B: begin
                if (axi.b_valid) begin
                    state_s   = DONE;
                    pready_s  = 1'b1;
                    pslverr_s = axi.b_resp[1];
                end else begin
                    b_ready_s = 1'b1;
                end
            end
            RD: begin
                if (axi.ar_ready) begin
                    ar_valid_s = 1'b0;
                    state_s    = WAIT_R;
                    r_ready_s  = 1'b1;
                end else begin
                    state_s = RD;
                end
            end
            WAIT_R: begin
                if (axi.r_valid) begin
                    prdata_s  = addr_r[2] ? axi.r_data[63:32] : axi.r_data[31:0];
                    state_s   = DONE;
                    pready_s  = 1'b1;
                    pslverr_s = axi.r_resp[1];
                end else begin
                    r_ready_s = 1'b1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s    = IDLE;
                aw_valid_s = 1'b0;
                w_valid_s  = 1'b0;
                ar_valid_s = 1'b0;
            end
        endcase
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= IDLE;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            prdata_r   <= 32'd0;
            aw_valid_r <= 1'b0;
            w_valid_r  <= 1'b0;
            ar_valid_r <= 1'b0;
            b_ready_r  <= 1'b0;
            r_ready_r  <= 1'b0;
            pready_r   <= 1'b0;
            pslverr_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            addr_r     <= addr_s;
            wdata_r    <= wdata_s;
            prdata_r   <= prdata_s;
            aw_valid_r <= aw_valid_s;
            w_valid_r  <= w_valid_s;
            ar_valid_r <= ar_valid_s;
            b_ready_r  <= b_ready_s;
            r_ready_r  <= r_ready_s;
            pready_r   <= pready_s;
            pslverr_r  <= pslverr_s;
        end
    end

    assign prdata_o  = prdata_r;
    assign pready_o  = pready_r;
    assign pslverr_o = pslverr_r;

    // Write address channel: single 32-bit beat, INCR, everything else zero.
    assign axi.aw_id     = AxiIdWidth'(AxiId);
    assign axi.aw_addr   = AxiAddrWidth'(addr_r);
    assign axi.aw_len    = 8'd0;
    assign axi.aw_size   = 3'd2;
    assign axi.aw_burst  = 2'b01;
    assign axi.aw_lock   = 1'b0;
    assign axi.aw_cache  = 4'd0;
    assign axi.aw_prot   = 3'd0;
    assign axi.aw_qos    = 4'd0;
    assign axi.aw_region = 4'd0;
    assign axi.aw_user   = {AxiUserWidth{1'b0}};
    assign axi.aw_valid  = aw_valid_r;

    // Write data: the word is replicated and the strobe selects the lane.
    assign axi.w_data  = AxiDataWidth'({wdata_r, wdata_r});
    assign axi.w_strb  = addr_r[2] ? 8'hF0 : 8'h0F;
    assign axi.w_last  = 1'b1;
    assign axi.w_user  = {AxiUserWidth{1'b0}};
    assign axi.w_valid = w_valid_r;

    assign axi.b_ready = b_ready_r;

    // Read address channel mirrors the write address attributes.
    assign axi.ar_id     = AxiIdWidth'(AxiId);
    assign axi.ar_addr   = AxiAddrWidth'(addr_r);
    assign axi.ar_len    = 8'd0;
    assign axi.ar_size   = 3'd2;
    assign axi.ar_burst  = 2'b01;
    assign axi.ar_lock   = 1'b0;
    assign axi.ar_cache  = 4'd0;
    assign axi.ar_prot   = 3'd0;
    assign axi.ar_qos    = 4'd0;
    assign axi.ar_region = 4'd0;
    assign axi.ar_user   = {AxiUserWidth{1'b0}};
    assign axi.ar_valid  = ar_valid_r;

    assign axi.r_ready = r_ready_r;

endmodule

// File: tb/tb_apb2axi_32_64.sv
// Directed testbench for apb2axi_32_64 with a small reactive AXI slave.
module tb_apb2axi_32_64;

    logic        clk_i;
    logic        rst_ni;
    logic        psel_i;
    logic        penable_i;
    logic        pwrite_i;
    logic [31:0] paddr_i;
    logic [31:0] pwdata_i;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;

    int n_checks = 0;
    int n_errors = 0;

    AXI_BUS #(
        .AXI_ADDR_WIDTH(64),
        .AXI_DATA_WIDTH(64),
        .AXI_ID_WIDTH  (4),
        .AXI_USER_WIDTH(1)
    ) axi_bus ();

    apb2axi_32_64 dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .psel_i   (psel_i),
        .penable_i(penable_i),
        .pwrite_i (pwrite_i),
        .paddr_i  (paddr_i),
        .pwdata_i (pwdata_i),
        .prdata_o (prdata_o),
        .pready_o (pready_o),
        .pslverr_o(pslverr_o),
        .axi      (axi_bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Per-access observations
    int          lat;
    logic        err_seen;
    int          aw_cycles;
    int          w_cycles;
    logic        any_valid;
    logic [63:0] aw_addr_seen;
    logic [63:0] ar_addr_seen;
    logic [63:0] w_data_seen;
    logic [7:0]  w_strb_seen;
    logic [2:0]  aw_size_seen;
    logic        aw_stable;

    task automatic slave_idle();
        axi_bus.aw_ready = 1'b0;
        axi_bus.w_ready  = 1'b0;
        axi_bus.b_valid  = 1'b0;
        axi_bus.b_resp   = 2'b00;
        axi_bus.ar_ready = 1'b0;
        axi_bus.r_valid  = 1'b0;
        axi_bus.r_resp   = 2'b00;
        axi_bus.r_data   = 64'd0;
    endtask

    // Issue one APB access (access phase sampled at cycle N) and serve AXI.
    task automatic apb_access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                              input int aw_dly, input logic [1:0] resp, input logic [63:0] rdata);
        lat = 0; err_seen = 1'b0; aw_cycles = 0; w_cycles = 0; any_valid = 1'b0;
        aw_addr_seen = 64'd0; ar_addr_seen = 64'd0; w_data_seen = 64'd0;
        w_strb_seen = 8'd0; aw_size_seen = 3'd0; aw_stable = 1'b1;
        @(negedge clk_i);
        psel_i = 1'b1; penable_i = 1'b1; pwrite_i = wr; paddr_i = addr; pwdata_i = data;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_i);
            if (axi_bus.aw_valid || axi_bus.w_valid || axi_bus.ar_valid) any_valid = 1'b1;
            if (axi_bus.aw_valid) begin
                if (aw_cycles > 0 && axi_bus.aw_addr !== aw_addr_seen) aw_stable = 1'b0;
                aw_cycles++;
                aw_addr_seen = axi_bus.aw_addr;
                aw_size_seen = axi_bus.aw_size;
            end
            if (axi_bus.w_valid) begin
                w_cycles++;
                w_data_seen = axi_bus.w_data;
                w_strb_seen = axi_bus.w_strb;
            end
            if (axi_bus.ar_valid) ar_addr_seen = axi_bus.ar_addr;
            axi_bus.aw_ready = axi_bus.aw_valid && (aw_cycles > aw_dly);
            axi_bus.w_ready  = axi_bus.w_valid;
            axi_bus.ar_ready = axi_bus.ar_valid;
            axi_bus.b_valid  = axi_bus.b_ready;
            axi_bus.b_resp   = resp;
            axi_bus.r_valid  = axi_bus.r_ready;
            axi_bus.r_resp   = resp;
            axi_bus.r_data   = rdata;
            if (pready_o) begin
                lat = k;
                err_seen = pslverr_o;
                break;
            end
        end
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
        slave_idle();
        if (lat == 0) check_value("pready_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        rst_ni = 1'b0;
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
        paddr_i = 32'd0; pwdata_i = 32'd0;
        slave_idle();
        axi_bus.b_id = 4'd0; axi_bus.b_user = 1'b0;
        axi_bus.r_id = 4'd0; axi_bus.r_user = 1'b0; axi_bus.r_last = 1'b1;

        // Reset values
        #12;
        check_value("rst_pready", 64'(pready_o), 64'd0);
        check_value("rst_pslverr", 64'(pslverr_o), 64'd0);
        check_value("rst_prdata", 64'(prdata_o), 64'd0);
        check_value("rst_valids", 64'({axi_bus.aw_valid, axi_bus.w_valid, axi_bus.ar_valid}), 64'd0);
        check_value("rst_readies", 64'({axi_bus.b_ready, axi_bus.r_ready}), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        // Write 0xDEADBEEF to 0x4, zero-wait slave
        apb_access(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 0, 2'b00, 64'd0);
        check_value("wr1_aw_addr", aw_addr_seen, 64'h4);
        check_value("wr1_w_data", w_data_seen, 64'hDEADBEEF_DEADBEEF);
        check_value("wr1_w_strb", 64'(w_strb_seen), 64'hF0);
        check_value("wr1_aw_size", 64'(aw_size_seen), 64'd2);
        check_value("wr1_latency", 64'(lat), 64'd3);
        check_value("wr1_pslverr", 64'(err_seen), 64'd0);
        check_value("wr1_prdata_kept", 64'(prdata_o), 64'd0);

        // Reads of both lanes
        apb_access(1'b0, 32'h0000_0008, 32'd0, 0, 2'b00, 64'h11112222_33334444);
        check_value("rd8_ar_addr", ar_addr_seen, 64'h8);
        check_value("rd8_latency", 64'(lat), 64'd3);
        check_value("rd8_prdata", 64'(prdata_o), 64'h33334444);
        check_value("rd8_pslverr", 64'(err_seen), 64'd0);
        apb_access(1'b0, 32'h0000_000C, 32'd0, 0, 2'b00, 64'h11112222_33334444);
        check_value("rdC_prdata", 64'(prdata_o), 64'h11112222);

        // Write with aw_ready delayed 5 cycles
        apb_access(1'b1, 32'h0000_0010, 32'hA5A5_0001, 5, 2'b00, 64'd0);
        check_value("wrdly_w_cycles", 64'(w_cycles), 64'd1);
        check_value("wrdly_aw_cycles", 64'(aw_cycles), 64'd6);
        check_value("wrdly_aw_stable", 64'(aw_stable), 64'd1);
        check_value("wrdly_latency", 64'(lat), 64'd8);
        check_value("wrdly_w_strb", 64'(w_strb_seen), 64'h0F);
        check_value("wrdly_prdata_kept", 64'(prdata_o), 64'h11112222);

        // Error responses
        apb_access(1'b1, 32'h0000_0020, 32'h1234_5678, 0, 2'b10, 64'd0);
        check_value("wrerr_pslverr", 64'(err_seen), 64'd1);
        check_value("wrerr_latency", 64'(lat), 64'd3);
        apb_access(1'b0, 32'h0000_0000, 32'd0, 0, 2'b11, 64'h55556666_77778888);
        check_value("rderr_pslverr", 64'(err_seen), 64'd1);
        check_value("rderr_prdata", 64'(prdata_o), 64'h77778888);

        // Misaligned access
        apb_access(1'b0, 32'h0000_0002, 32'd0, 0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF);
        check_value("mis_latency", 64'(lat), 64'd1);
        check_value("mis_pslverr", 64'(err_seen), 64'd1);
        check_value("mis_no_axi", 64'(any_valid), 64'd0);
        check_value("mis_prdata_kept", 64'(prdata_o), 64'h77778888);

        // Async reset while waiting for R
        begin
            logic reached;
            reached = 1'b0;
            @(negedge clk_i);
            psel_i = 1'b1; penable_i = 1'b1; pwrite_i = 1'b0; paddr_i = 32'h0000_0014;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk_i);
                axi_bus.ar_ready = axi_bus.ar_valid;
                if (axi_bus.r_ready) begin
                    reached = 1'b1;
                    break;
                end
            end
            check_value("rst_reach_wait_r", 64'(reached), 64'd1);
            #2 rst_ni = 1'b0;
            #1;
            check_value("arst_pready", 64'(pready_o), 64'd0);
            check_value("arst_pslverr", 64'(pslverr_o), 64'd0);
            check_value("arst_prdata", 64'(prdata_o), 64'd0);
            check_value("arst_valids", 64'({axi_bus.aw_valid, axi_bus.w_valid, axi_bus.ar_valid}), 64'd0);
            check_value("arst_readies", 64'({axi_bus.b_ready, axi_bus.r_ready}), 64'd0);
            psel_i = 1'b0; penable_i = 1'b0;
            slave_idle();
            @(negedge clk_i);
            rst_ni = 1'b1;
            @(negedge clk_i);
        end
        apb_access(1'b0, 32'h0000_0014, 32'd0, 0, 2'b00, 64'hAAAABBBB_CCCCDDDD);
        check_value("postrst_latency", 64'(lat), 64'd3);
        check_value("postrst_prdata", 64'(prdata_o), 64'hAAAABBBB);
        check_value("postrst_pslverr", 64'(err_seen), 64'd0);

        repeat (2) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
